// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file write port between NREQ
// writeback requesters, plus a pending-write scoreboard for RAW hazard lookup.
module regfile_wb_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*N-1:0]     req_rd,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  wenable,
  output logic [N-1:0]          reg_in,
  output logic [WIDTH-1:0]      din,
  input  logic                  issue_valid,
  input  logic [N-1:0]          issue_rd,
  input  logic [N-1:0]          a,
  input  logic [N-1:0]          b,
  output logic                  busy_a,
  output logic                  busy_b
);

  localparam int unsigned NREGS = 1 << N;
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wenable_q, wenable_d;
  logic [N-1:0]     reg_in_q, reg_in_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [NREGS-1:0] busy_q, busy_d;

  logic [NREQ-1:0]  grant;
  logic             grant_any;
  logic [PTR_W-1:0] gnt_idx;
  logic [N-1:0]     sel_rd;
  logic [WIDTH-1:0] sel_data;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin : arb
    int unsigned j;
    grant     = '0;
    grant_any = 1'b0;
    gnt_idx   = '0;
    sel_rd    = '0;
    sel_data  = '0;
    j         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(rr_ptr_q) + k) % NREQ;
      if (!grant_any && req_valid[j]) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        gnt_idx   = PTR_W'(j);
        sel_rd    = req_rd[j*N +: N];
        sel_data  = req_data[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : next_state
    rr_ptr_d  = rr_ptr_q;
    wenable_d = 1'b0;
    reg_in_d  = reg_in_q;
    din_d     = din_q;
    busy_d    = busy_q;
    if (grant_any) begin
      rr_ptr_d  = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      wenable_d = (sel_rd != '0);
      reg_in_d  = sel_rd;
      din_d     = sel_data;
    end
    if (wenable_q) begin
      busy_d[reg_in_q] = 1'b0;
    end
    // A newly allocated producer wins over the retiring write to the same rd.
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      wenable_q <= 1'b0;
      reg_in_q  <= '0;
      din_q     <= '0;
      busy_q    <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wenable_q <= wenable_d;
      reg_in_q  <= reg_in_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
    end
  end

  assign req_ready = grant;
  assign wenable   = wenable_q;
  assign reg_in    = reg_in_q;
  assign din       = din_q;
  assign busy_a    = busy_q[a];
  assign busy_b    = busy_q[b];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (N=5, WIDTH=32, NREQ=3).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wenable;
  logic [4:0]  reg_in;
  logic [31:0] din;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  a;
  logic [4:0]  b;
  logic        busy_a;
  logic        busy_b;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.N(5), .WIDTH(32), .NREQ(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .wenable(wenable), .reg_in(reg_in), .din(din),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .a(a), .b(b), .busy_a(busy_a), .busy_b(busy_b)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sweeps every address on both lookup ports; each busy bit must be clear.
  task automatic chk_all_idle(input string tag);
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      b = 5'(31 - i);
      #1;
      chk(tag, {63'd0, busy_a}, 64'd0);
      chk(tag, {63'd0, busy_b}, 64'd0);
    end
  endtask

  logic [2:0]  rr_exp [4];
  logic [31:0] rr_data [3];

  initial begin
    rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; a = '0; b = '0;

    // Reset with random activity on the inputs
    @(negedge clk);
    req_valid = 3'($urandom); issue_valid = 1'b1; issue_rd = 5'($urandom);
    @(negedge clk);
    req_valid = 3'($urandom); issue_rd = 5'($urandom);
    @(negedge clk);
    req_valid = 3'b111; issue_valid = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'b001);
    chk("rst_wen", 64'(wenable), 64'd0);
    chk("rst_reg_in", 64'(reg_in), 64'd0);
    chk("rst_din", 64'(din), 64'd0);
    chk_all_idle("rst_busy");

    // Single write to r15 from requester 1
    @(negedge clk);
    rst = 1'b0; req_valid = '0; issue_valid = 1'b1; issue_rd = 5'd15;
    @(negedge clk);
    issue_valid = 1'b0; a = 5'd15;
    req_valid = 3'b010; req_rd[5 +: 5] = 5'd15; req_data[32 +: 32] = 32'd2047;
    #1;
    chk("single_busy_set", 64'(busy_a), 64'd1);
    chk("single_ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single_wen", 64'(wenable), 64'd1);
    chk("single_reg_in", 64'(reg_in), 64'd15);
    chk("single_din", 64'(din), 64'd2047);
    chk("single_busy_hold", 64'(busy_a), 64'd1);
    @(negedge clk);
    #1;
    chk("single_busy_clr", 64'(busy_a), 64'd0);
    chk("single_wen_drop", 64'(wenable), 64'd0);

    // Round robin from a freshly reset pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    rr_data[0] = 32'd10; rr_data[1] = 32'd20; rr_data[2] = 32'd30;
    req_rd = {5'd3, 5'd2, 5'd1};
    req_data = {32'd30, 32'd20, 32'd10};
    req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(rr_exp[c]));
      if (c > 0) begin
        chk("rr_wen", 64'(wenable), 64'd1);
        chk("rr_din", 64'(din), 64'(rr_data[c - 1]));
      end
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    chk("rr_wen_last", 64'(wenable), 64'd1);
    chk("rr_din_last", 64'(din), 64'd10);

    // Fairness with gaps: pointer is now 1
    @(negedge clk);
    req_rd = {5'd6, 5'd0, 5'd4};
    req_data = {32'd300, 32'd0, 32'd100};
    req_valid = 3'b100;
    #1;
    chk("fair_ready_r2", 64'(req_ready), 64'b100);
    @(negedge clk);
    req_valid = 3'b101;
    #1;
    chk("fair_ready_r0", 64'(req_ready), 64'b001);
    chk("fair_din_r2", 64'(din), 64'd300);
    @(negedge clk);
    #1;
    chk("fair_ready_r2b", 64'(req_ready), 64'b100);
    chk("fair_din_r0", 64'(din), 64'd100);
    chk("fair_reg_in_r0", 64'(reg_in), 64'd4);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("fair_din_r2b", 64'(din), 64'd300);
    chk("fair_wen", 64'(wenable), 64'd1);

    // Write and issue to r0: consumed but never enables a write
    @(negedge clk);
    req_valid = 3'b001; req_rd[0 +: 5] = 5'd0; req_data[0 +: 32] = 32'd2047;
    issue_valid = 1'b1; issue_rd = 5'd0; a = 5'd0;
    #1;
    chk("r0_ready", 64'(req_ready), 64'b001);
    chk("r0_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    req_valid = '0; issue_valid = 1'b0;
    #1;
    chk("r0_wen", 64'(wenable), 64'd0);
    chk("r0_busy_after", 64'(busy_a), 64'd0);
    chk("r0_din", 64'(din), 64'd2047);

    // Set/clear collision on r7: pointer is now 1
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd7; a = 5'd7;
    @(negedge clk);
    issue_valid = 1'b0;
    req_valid = 3'b010; req_rd[5 +: 5] = 5'd7; req_data[32 +: 32] = 32'd77;
    #1;
    chk("coll_busy_set", 64'(busy_a), 64'd1);
    chk("coll_ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    req_valid = '0; issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("coll_wen", 64'(wenable), 64'd1);
    chk("coll_reg_in", 64'(reg_in), 64'd7);
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    chk("coll_busy_kept", 64'(busy_a), 64'd1);

    // Reset while a write is on the port: pointer is now 2
    req_valid = 3'b100; req_rd[10 +: 5] = 5'd9; req_data[64 +: 32] = 32'd99;
    issue_valid = 1'b1; issue_rd = 5'd20;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'b100);
    @(negedge clk);
    req_valid = '0; issue_valid = 1'b0; a = 5'd20; b = 5'd7;
    #1;
    chk("midrst_wen_pre", 64'(wenable), 64'd1);
    chk("midrst_busy20_pre", 64'(busy_a), 64'd1);
    chk("midrst_busy7_pre", 64'(busy_b), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_wen", 64'(wenable), 64'd0);
    chk("midrst_reg_in", 64'(reg_in), 64'd0);
    chk("midrst_din", 64'(din), 64'd0);
    chk_all_idle("midrst_busy");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
